// File: rtl/nfc_copy_ctrl.sv
// NAND flash copy controller: streams every page of flash A into flash B, one byte at a time.
// The control context is triplicated and majority-voted every cycle; bus outputs decode from the vote.
module nfc_ctx_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else     q <= d;
endmodule

module nfc_copy_ctrl #(
  parameter int PAGES      = 512,
  parameter int PAGE_BYTES = 512
) (
  input  logic       clk,
  input  logic       rst,
  output logic       done,
  inout  wire  [7:0] F_IO_A,
  output logic       F_CLE_A,
  output logic       F_ALE_A,
  output logic       F_REN_A,
  output logic       F_WEN_A,
  input  logic       F_RB_A,
  inout  wire  [7:0] F_IO_B,
  output logic       F_CLE_B,
  output logic       F_ALE_B,
  output logic       F_REN_B,
  output logic       F_WEN_B,
  input  logic       F_RB_B,
  input  logic       A_error_ctrl,
  input  logic       B_error_ctrl,
  input  logic       C_error_ctrl,
  output logic       TMR_error
);
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int BW = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_CMD, S_RD_ADDR, S_RD_WAIT, S_PG_CMD, S_PG_ADDR,
    S_XFER, S_PG_CONF, S_PG_WAIT, S_NEXT, S_DONE, S_HALT
  } state_t;

  typedef struct packed {
    state_t          state;
    logic [PW-1:0]   page;
    logic [BW-1:0]   bcnt;
    logic [2:0]      sub;
  } ctx_t;

  localparam int CW = $bits(ctx_t);
  localparam logic [PW-1:0] LAST_PG = PW'(PAGES - 1);
  localparam logic [BW-1:0] LAST_B  = BW'(PAGE_BYTES - 1);

  logic [CW-1:0] rep [3];
  logic [CW-1:0] vv;
  logic [2:0]    fault;
  ctx_t          v, n;
  logic [7:0]    data_q, addr_byte, io_a_o, io_b_o;
  logic [8:0]    pg9;
  logic          oe_a, oe_b, mismatch, tmr_q;

  assign fault = {C_error_ctrl, B_error_ctrl, A_error_ctrl};

  // Every replica reloads the voted next context, so a corrupted copy heals in one cycle.
  for (genvar i = 0; i < 3; i++) begin : g_rep
    nfc_ctx_reg #(.W(CW)) u_rep (
      .clk (clk),
      .rst (rst),
      .d   (n ^ {CW{fault[i]}}),
      .q   (rep[i])
    );
  end

  assign vv       = (rep[0] & rep[1]) | (rep[1] & rep[2]) | (rep[0] & rep[2]);
  assign v        = ctx_t'(vv);
  assign mismatch = (rep[0] != vv) || (rep[1] != vv) || (rep[2] != vv);

  always_ff @(posedge clk)
    if (rst)           tmr_q <= 1'b0;
    else if (mismatch) tmr_q <= 1'b1;

  assign TMR_error = tmr_q | mismatch;

  // Single byte register: A data lands at the end of the REN-low phase.
  always_ff @(posedge clk)
    if (rst)                                      data_q <= '0;
    else if (v.state == S_XFER && v.sub == 3'd0)  data_q <= F_IO_A;

  always_comb begin
    n     = v;
    n.sub = v.sub + 3'd1;
    case (v.state)
      S_IDLE: begin
        n       = '0;
        n.state = S_RD_CMD;
      end
      S_RD_CMD:  if (v.sub == 3'd1) begin n.state = S_RD_ADDR; n.sub = '0; end
      S_RD_ADDR: if (v.sub == 3'd5) begin n.state = S_RD_WAIT; n.sub = '0; end
      S_RD_WAIT: if (v.sub == 3'd2) begin
        n.sub = v.sub;
        if (F_RB_A) begin n.state = S_PG_CMD; n.sub = '0; end
      end
      S_PG_CMD:  if (v.sub == 3'd1) begin n.state = S_PG_ADDR; n.sub = '0; end
      S_PG_ADDR: if (v.sub == 3'd5) begin n.state = S_XFER; n.sub = '0; n.bcnt = '0; end
      S_XFER: if (v.sub == 3'd3) begin
        n.sub = '0;
        if (v.bcnt == LAST_B) begin n.state = S_PG_CONF; n.bcnt = '0; end
        else n.bcnt = v.bcnt + BW'(1);
      end
      S_PG_CONF: if (v.sub == 3'd1) begin n.state = S_PG_WAIT; n.sub = '0; end
      S_PG_WAIT: if (v.sub == 3'd2) begin
        n.sub = v.sub;
        if (F_RB_B) begin n.state = S_NEXT; n.sub = '0; end
      end
      S_NEXT: begin
        n.sub = '0;
        if (v.page == LAST_PG) n.state = S_DONE;
        else begin n.page = v.page + PW'(1); n.state = S_RD_CMD; end
      end
      S_DONE:  begin n.state = S_HALT; n.sub = '0; end
      default: begin n.state = S_HALT; n.sub = '0; end
    endcase
  end

  assign pg9 = 9'(v.page);

  always_comb begin
    case (v.sub[2:1])
      2'd1:    addr_byte = pg9[7:0];
      2'd2:    addr_byte = {7'b0, pg9[8]};
      default: addr_byte = 8'h00;
    endcase
  end

  // Write byte: even sub-phase WEN low, odd sub-phase WEN high with IO held.
  always_comb begin
    F_CLE_A = 1'b0; F_ALE_A = 1'b0; F_REN_A = 1'b1; F_WEN_A = 1'b1;
    F_CLE_B = 1'b0; F_ALE_B = 1'b0; F_REN_B = 1'b1; F_WEN_B = 1'b1;
    oe_a = 1'b0; io_a_o = 8'h00; oe_b = 1'b0; io_b_o = 8'h00; done = 1'b0;
    case (v.state)
      S_RD_CMD:  begin F_CLE_A = 1'b1; F_WEN_A = v.sub[0]; oe_a = 1'b1; io_a_o = 8'h00; end
      S_RD_ADDR: begin F_ALE_A = 1'b1; F_WEN_A = v.sub[0]; oe_a = 1'b1; io_a_o = addr_byte; end
      S_PG_CMD:  begin F_CLE_B = 1'b1; F_WEN_B = v.sub[0]; oe_b = 1'b1; io_b_o = 8'h80; end
      S_PG_ADDR: begin F_ALE_B = 1'b1; F_WEN_B = v.sub[0]; oe_b = 1'b1; io_b_o = addr_byte; end
      S_XFER: begin
        F_REN_A = (v.sub != 3'd0);
        if (v.sub[1]) begin F_WEN_B = v.sub[0]; oe_b = 1'b1; io_b_o = data_q; end
      end
      S_PG_CONF: begin F_CLE_B = 1'b1; F_WEN_B = v.sub[0]; oe_b = 1'b1; io_b_o = 8'h10; end
      S_DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign F_IO_A = oe_a ? io_a_o : 8'hzz;
  assign F_IO_B = oe_b ? io_b_o : 8'hzz;
endmodule

// File: tb/tb_nfc_copy_ctrl.sv
// Directed bench: behavioural flash A/B models, protocol monitor and per-run copy scoreboard.
`timescale 1ns/1ps
module tb_nfc_copy_ctrl;
  localparam int PAGES = 258;  // spans the row1 (page bit 8) boundary
  localparam int PB    = 4;
  localparam int NB    = PAGES * PB;
  localparam logic [8:0] IDLE_V = 9'b0_0_1_1_0_0_1_1_0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  wire  [7:0] io_a, io_b;
  logic cle_a, ale_a, ren_a, wen_a, cle_b, ale_b, ren_b, wen_b;
  logic rb_a, rb_b, done, tmr_error;
  logic a_err = 1'b0, b_err = 1'b0, c_err = 1'b0;

  int   n_chk = 0, n_fail = 0;
  int   sel = 0;
  logic clr = 1'b1;

  int   busy_a, busy_b, a_pg, a_col, a_na, a_first, a_reads;
  int   b_pg, b_col, b_na, b_dn, b_prog, done_cnt;
  logic [7:0] a_c, a_r0, b_c, b_r0, pio_a, pio_b, a_dout;
  logic pw_a, pr_a, pcle_a, pale_a, pw_b, pr_b, pcle_b, pale_b, perr;
  logic [7:0] mem_b [NB];

  nfc_copy_ctrl #(.PAGES(PAGES), .PAGE_BYTES(PB)) dut (
    .clk(clk), .rst(rst), .done(done),
    .F_IO_A(io_a), .F_CLE_A(cle_a), .F_ALE_A(ale_a), .F_REN_A(ren_a), .F_WEN_A(wen_a), .F_RB_A(rb_a),
    .F_IO_B(io_b), .F_CLE_B(cle_b), .F_ALE_B(ale_b), .F_REN_B(ren_b), .F_WEN_B(wen_b), .F_RB_B(rb_b),
    .A_error_ctrl(a_err), .B_error_ctrl(b_err), .C_error_ctrl(c_err), .TMR_error(tmr_error)
  );

  function automatic logic [7:0] pat(input int s, input int p, input int k);
    logic [7:0] pb, kb;
    pb = p[7:0];
    kb = k[7:0];
    if (s == 0) return 8'(p * 37 + k * 11 + 90 + (p >> 8) * 77);
    return kb ^ pb;
  endfunction

  assign a_dout = pat(sel, a_pg, a_col);
  assign io_a   = ren_a ? 8'hzz : a_dout;
  assign rb_a   = (busy_a == 0);
  assign rb_b   = (busy_b == 0);

  // Flash models commit a byte on the WEN rising edge, as observed on the falling clock edge.
  always @(negedge clk) begin
    pw_a <= wen_a; pr_a <= ren_a; pcle_a <= cle_a; pale_a <= ale_a; pio_a <= io_a;
    pw_b <= wen_b; pr_b <= ren_b; pcle_b <= cle_b; pale_b <= ale_b; pio_b <= io_b;
    if (busy_a != 0) busy_a <= busy_a - 1;
    if (busy_b != 0) busy_b <= busy_b - 1;
    if (done) done_cnt <= done_cnt + 1;
    if (rst) a_first <= -1;
    if ((!rb_a && (wen_a != pw_a || ren_a != pr_a)) ||
        (!rb_b && (wen_b != pw_b || ren_b != pr_b)) || !ren_b) perr <= 1'b1;

    if (!pw_a && wen_a) begin
      if (io_a != pio_a || cle_a != pcle_a || ale_a != pale_a) perr <= 1'b1;
      if (cle_a) begin
        if (ale_a || io_a != 8'h00) perr <= 1'b1;
        a_na <= 0;
      end else if (ale_a) begin
        a_na <= a_na + 1;
        if (a_na == 0) a_c <= io_a;
        else if (a_na == 1) a_r0 <= io_a;
        else if (a_na == 2) begin
          a_pg   <= int'({io_a[0], a_r0});
          a_col  <= 0;
          busy_a <= 4;
          if (a_c != 8'h00 || io_a[7:1] != 7'd0) perr <= 1'b1;
          if (a_first < 0) a_first <= int'({io_a[0], a_r0});
        end else perr <= 1'b1;
      end else perr <= 1'b1;
    end
    if (!pr_a && ren_a) begin
      a_col   <= a_col + 1;
      a_reads <= a_reads + 1;
    end

    if (!pw_b && wen_b) begin
      if (io_b != pio_b || cle_b != pcle_b || ale_b != pale_b) perr <= 1'b1;
      if (cle_b) begin
        if (ale_b) perr <= 1'b1;
        if (io_b == 8'h80) begin b_na <= 0; b_dn <= 0; end
        else if (io_b == 8'h10) begin
          if (b_na != 3 || b_dn != PB) perr <= 1'b1;
          busy_b <= 4;
          b_prog <= b_prog + 1;
        end else perr <= 1'b1;
      end else if (ale_b) begin
        b_na <= b_na + 1;
        if (b_na == 0) b_c <= io_b;
        else if (b_na == 1) b_r0 <= io_b;
        else if (b_na == 2) begin
          b_pg  <= int'({io_b[0], b_r0});
          b_col <= 0;
          if (b_c != 8'h00 || io_b[7:1] != 7'd0) perr <= 1'b1;
        end else perr <= 1'b1;
      end else begin
        if (b_na != 3 || b_col >= PB || b_pg >= PAGES) perr <= 1'b1;
        else mem_b[b_pg * PB + b_col] <= io_b;
        b_col <= b_col + 1;
        b_dn  <= b_dn + 1;
      end
    end

    if (clr) begin
      busy_a <= 0; busy_b <= 0; a_pg <= 0; a_col <= 0; a_na <= 0; a_first <= -1; a_reads <= 0;
      b_pg <= 0; b_col <= 0; b_na <= 0; b_dn <= 0; b_prog <= 0; done_cnt <= 0; perr <= 1'b0;
      for (int i = 0; i < NB; i++) mem_b[i] <= ~pat(sel, i / PB, i % PB);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run(input string tag, input int s);
    sel = s; rst = 1'b1; clr = 1'b1;
    repeat (3) tick();
    clr = 1'b0; rst = 1'b0;
    chk({tag, "_reset_idle"}, {cle_a, ale_a, ren_a, wen_a, cle_b, ale_b, ren_b, wen_b, done}, IDLE_V);
    chk({tag, "_reset_tmr"}, tmr_error, 0);
  endtask

  task automatic finish_run(input string tag, input int exp_prog, input int exp_reads, input int exp_tmr);
    bit seen;
    int mism;
    seen = 1'b0;
    for (int i = 0; i < 14000 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    repeat (8) tick();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_halt_idle"}, {cle_a, ale_a, ren_a, wen_a, cle_b, ale_b, ren_b, wen_b, done}, IDLE_V);
    mism = 0;
    for (int i = 0; i < NB; i++) if (mem_b[i] != pat(sel, i / PB, i % PB)) mism++;
    chk({tag, "_copy_mism"}, mism, 0);
    chk({tag, "_last_byte"}, mem_b[NB-1], pat(sel, PAGES - 1, PB - 1));
    chk({tag, "_protocol"}, perr, 0);
    chk({tag, "_pages_prog"}, b_prog, exp_prog);
    chk({tag, "_reads"}, a_reads, exp_reads);
    chk({tag, "_tmr"}, tmr_error, exp_tmr);
  endtask

  initial begin
    bit found;

    start_run("t1", 0);
    finish_run("t1", PAGES, NB, 0);

    start_run("t2", 1);
    finish_run("t2", PAGES, NB, 0);

    start_run("t3", 0);
    repeat (2500) tick();
    chk("t3_tmr_pre", tmr_error, 0);
    a_err = 1'b1;
    repeat (3) tick();
    chk("t3_tmr_set", tmr_error, 1);
    finish_run("t3", PAGES, NB, 1);
    a_err = 1'b0;

    start_run("t4", 1);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin tick(); if (!ren_a) found = 1'b1; end
    chk("t4_xfer_seen", found, 1);
    b_err = 1'b1; tick(); b_err = 1'b0; tick();
    chk("t4_tmr_b", tmr_error, 1);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin tick(); if (!rb_b) found = 1'b1; end
    chk("t4_pgwait_seen", found, 1);
    c_err = 1'b1; tick(); c_err = 1'b0;
    finish_run("t4", PAGES, NB, 1);

    start_run("t5", 0);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin tick(); if (b_prog == 3 && !ren_a) found = 1'b1; end
    chk("t5_page3_seen", found, 1);
    rst = 1'b1; tick();
    chk("t5_abort_idle", {cle_a, ale_a, ren_a, wen_a, cle_b, ale_b, ren_b, wen_b, done}, IDLE_V);
    rst = 1'b0;
    finish_run("t5", PAGES + 3, NB + 3 * PB + 1, 0);
    chk("t5_restart_page", a_first, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1600000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
